pe_array_id_loader: RTL
=======================

PE_ARRAY_ID_LOADER -- requirements
Module: pe_array_id_loader

Interface
REQ-001 SHALL have parameter ROWS, default 6, physical PE array rows.
REQ-002 SHALL have parameter COLS, default 8, physical PE array columns.
REQ-003 SHALL have parameter XID_W, default 5, X-ID width; parameter YID_W, default 3, Y-ID width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to program all ID registers.
REQ-007 SHALL have port PE_ARRAY_H  input  3  active rows; PE_ARRAY_W  input  4  active columns.
REQ-008 SHALL have ports filter_XID, ifmap_XID, ipsum_XID, opsum_XID  input  ROWS*COLS*XID_W each  flattened row-major X-IDs from pe_array_id_generator; entry i at bits [i*XID_W +: XID_W].
REQ-009 SHALL have ports filter_YID, ifmap_YID, ipsum_YID, opsum_YID  input  ROWS*YID_W each  flattened per-row Y-IDs.
REQ-010 SHALL have port cfg_valid  output  1  config beat valid; cfg_ready  input  1  PE array accepts beat.
REQ-011 SHALL have ports cfg_type  output  2  (0 filter, 1 ifmap, 2 ipsum, 3 opsum); cfg_is_y  output  1  (1 = Y-ID beat); cfg_row  output  3; cfg_col  output  4; cfg_id  output  XID_W (Y-IDs zero-extended).
REQ-012 SHALL have ports busy  output  1; done  output  1  one-cycle completion pulse; err  output  1  one-cycle illegal-size pulse.

Function
REQ-013 SHALL implement states IDLE, YPASS, XPASS, FIN.
REQ-014 In IDLE with start=1, SHALL latch PE_ARRAY_H, PE_ARRAY_W and all ID inputs into internal registers; later input changes SHALL NOT affect the current sequence.
REQ-015 If latched H=0, H>ROWS, W=0 or W>COLS, SHALL pulse err the next cycle, issue no beats, remain IDLE.
REQ-016 Otherwise SHALL enter YPASS with cfg_type=0, row=0, and assert cfg_valid the cycle after start (latency 1).
REQ-017 YPASS SHALL emit one beat per row 0..H-1: cfg_is_y=1, cfg_col=0, cfg_id=YID[row] of current type.
REQ-018 XPASS SHALL emit row-major beats for row 0..H-1, col 0..W-1: cfg_is_y=0, cfg_id=XID[row*COLS+col] of current type.
REQ-019 After XPASS of type t<3 SHALL return to YPASS with t+1; after type 3 SHALL enter FIN.
REQ-020 A beat is transferred only when cfg_valid&&cfg_ready; counters advance only on transfer.
REQ-021 While cfg_valid=1 and cfg_ready=0, all cfg_* outputs SHALL hold stable; cfg_valid SHALL NOT drop before transfer.
REQ-022 With cfg_ready held high, one beat per cycle, no bubbles across Y/X or type boundaries; total beats = 4*(H + H*W).
REQ-023 FIN SHALL pulse done for exactly one cycle with cfg_valid=0, then return to IDLE.
REQ-024 busy SHALL be 1 from cycle after accepted start through the FIN cycle inclusive.
REQ-025 start while not IDLE SHALL be ignored.
REQ-026 All-ones IDs (31 X, 7 Y; unused PE marker) SHALL be transferred unmodified.
REQ-027 cfg_* outputs SHALL be registered; cfg_id/row/col/type SHALL be 0 when cfg_valid=0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, cfg_valid=0, busy=0, done=0, err=0, all cfg_* and counters 0.
REQ-029 Reset mid-sequence SHALL abandon it without done; first start after reset restarts from type 0, row 0.

Verification
REQ-030 H=6, W=8, cfg_ready=1, start pulse -> 216 consecutive beats, first beat cycle after start, done one cycle after 216th transfer, busy high 217 cycles.
REQ-031 H=6, W=8, generator setting p=4,q=4,r=2,t=2,e=4,t_H=1,t_W=2,LINEAR=0 -> beat sequence equals golden model's filter/ifmap/ipsum/opsum Y then X IDs in order.
REQ-032 H=2, W=3, cfg_ready random 50% -> 4*(2+6)=32 transfers, outputs stable during every stall, beat order unchanged.
REQ-033 H=0 or W=9 with start -> err pulse next cycle, zero beats, busy stays 0.
REQ-034 rst_n low on beat 100 of REQ-030 run -> outputs 0 asynchronously, no done; new start -> full 216-beat sequence from filter row 0.
REQ-035 start re-pulsed during busy and ID inputs changed mid-run -> ignored; transferred IDs match values latched at original start.

Source files
------------

// File: rtl/pe_array_id_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pe_array_id_loader
// Purpose: takes one snapshot of the PE-array X/Y ID tables on start. It then
// streams them to the PE array as valid/ready configuration beats. For each
// ID type (filter, ifmap, ipsum, opsum) it sends the H per-row Y-IDs and then
// the H*W X-IDs in row-major order. After the last beat it pulses done.
// An illegal array size produces an err pulse and no beats.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle request, honoured only when idle
//   PE_ARRAY_H, PE_ARRAY_W     active rows / columns
//   *_XID                      ROWS*COLS*XID_W flattened row-major X-IDs
//   *_YID                      ROWS*YID_W flattened per-row Y-IDs
//   cfg_valid/cfg_ready        beat handshake
//   cfg_type/is_y/row/col/id   beat payload (zero while cfg_valid is low)
//   busy, done, err            status; done and err are one-cycle pulses
// -----------------------------------------------------------------------------
module pe_array_id_loader #(
  parameter int ROWS  = 6,
  parameter int COLS  = 8,
  parameter int XID_W = 5,
  parameter int YID_W = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [2:0]                  PE_ARRAY_H,
  input  logic [3:0]                  PE_ARRAY_W,
  input  logic [ROWS*COLS*XID_W-1:0]  filter_XID,
  input  logic [ROWS*COLS*XID_W-1:0]  ifmap_XID,
  input  logic [ROWS*COLS*XID_W-1:0]  ipsum_XID,
  input  logic [ROWS*COLS*XID_W-1:0]  opsum_XID,
  input  logic [ROWS*YID_W-1:0]       filter_YID,
  input  logic [ROWS*YID_W-1:0]       ifmap_YID,
  input  logic [ROWS*YID_W-1:0]       ipsum_YID,
  input  logic [ROWS*YID_W-1:0]       opsum_YID,
  output logic                        cfg_valid,
  input  logic                        cfg_ready,
  output logic [1:0]                  cfg_type,
  output logic                        cfg_is_y,
  output logic [2:0]                  cfg_row,
  output logic [3:0]                  cfg_col,
  output logic [XID_W-1:0]            cfg_id,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int NPE    = ROWS * COLS;
  localparam int IDX_W  = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_YPASS, S_XPASS, S_FIN} state_t;

  state_t            r_state, w_state;
  logic [1:0]        r_type, w_type;
  logic [2:0]        r_row, w_row;
  logic [3:0]        r_col, w_col;
  logic              r_valid, w_valid;
  logic              r_is_y, w_is_y;
  logic [XID_W-1:0]  r_id, w_id;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic [2:0]        r_h;
  logic [3:0]        r_w;
  logic              w_load;
  logic              w_bad;
  logic              w_xfer;
  logic [IDX_W-1:0]  w_idx;

  // Snapshot of the ID tables, indexed [type][entry]
  logic [XID_W-1:0]  r_xid [4][NPE];
  logic [YID_W-1:0]  r_yid [4][ROWS];

  // Zero-extend a Y-ID to the beat payload width
  function automatic logic [XID_W-1:0] zext_y(input logic [YID_W-1:0] y);
    return {{(XID_W-YID_W){1'b0}}, y};
  endfunction

  assign w_xfer = r_valid & cfg_ready;
  assign w_bad  = (PE_ARRAY_H == 3'd0) || (32'(PE_ARRAY_H) > ROWS) ||
                  (PE_ARRAY_W == 4'd0) || (32'(PE_ARRAY_W) > COLS);

  // Next-state and next-beat sequencing; everything holds unless a beat transfers
  always_comb begin
    w_state = r_state;
    w_type  = r_type;
    w_row   = r_row;
    w_col   = r_col;
    w_valid = r_valid;
    w_is_y  = r_is_y;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          if (w_bad) begin
            w_err = 1'b1;
          end else begin
            w_state = S_YPASS;
            w_type  = 2'd0;
            w_row   = 3'd0;
            w_col   = 4'd0;
            w_valid = 1'b1;
            w_is_y  = 1'b1;
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_YPASS: begin
        if (w_xfer) begin
          if (r_row == r_h - 3'd1) begin
            w_state = S_XPASS;
            w_row   = 3'd0;
            w_col   = 4'd0;
            w_is_y  = 1'b0;
          end else begin
            w_row = r_row + 3'd1;
          end
        end else begin
          w_state = S_YPASS;
        end
      end
      S_XPASS: begin
        if (w_xfer) begin
          if (r_col == r_w - 4'd1) begin
            if (r_row == r_h - 3'd1) begin
              if (r_type == 2'd3) begin
                // Last beat of opsum: drop valid and clear the payload
                w_state = S_FIN;
                w_type  = 2'd0;
                w_row   = 3'd0;
                w_col   = 4'd0;
                w_valid = 1'b0;
                w_is_y  = 1'b0;
                w_done  = 1'b1;
              end else begin
                w_state = S_YPASS;
                w_type  = r_type + 2'd1;
                w_row   = 3'd0;
                w_col   = 4'd0;
                w_is_y  = 1'b1;
              end
            end else begin
              w_row = r_row + 3'd1;
              w_col = 4'd0;
            end
          end else begin
            w_col = r_col + 4'd1;
          end
        end else begin
          w_state = S_XPASS;
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_type  = 2'd0;
        w_row   = 3'd0;
        w_col   = 4'd0;
        w_valid = 1'b0;
        w_is_y  = 1'b0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // Payload lookup for the next beat. The first beat is read straight from the
  // inputs because the snapshot is being written on that same edge.
  always_comb begin
    w_id  = {XID_W{1'b0}};
    w_idx = IDX_W'(w_row) * IDX_W'(COLS) + IDX_W'(w_col);
    if (!w_valid) begin
      w_id = {XID_W{1'b0}};
    end else if (w_load) begin
      w_id = zext_y(filter_YID[YID_W-1:0]);
    end else if (w_is_y) begin
      w_id = zext_y(r_yid[w_type][RIDX_W'(w_row)]);
    end else begin
      w_id = r_xid[w_type][w_idx];
    end
  end

  // Control/output registers and the ID snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_type  <= 2'd0;
      r_row   <= 3'd0;
      r_col   <= 4'd0;
      r_valid <= 1'b0;
      r_is_y  <= 1'b0;
      r_id    <= {XID_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_h     <= 3'd0;
      r_w     <= 4'd0;
      for (int t = 0; t < 4; t++) begin
        for (int i = 0; i < NPE; i++) r_xid[t][i] <= {XID_W{1'b0}};
        for (int r = 0; r < ROWS; r++) r_yid[t][r] <= {YID_W{1'b0}};
      end
    end else begin
      r_state <= w_state;
      r_type  <= w_type;
      r_row   <= w_row;
      r_col   <= w_col;
      r_valid <= w_valid;
      r_is_y  <= w_is_y;
      r_id    <= w_id;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      if (w_load) begin
        r_h <= PE_ARRAY_H;
        r_w <= PE_ARRAY_W;
        for (int i = 0; i < NPE; i++) begin
          r_xid[0][i] <= filter_XID[i*XID_W +: XID_W];
          r_xid[1][i] <= ifmap_XID[i*XID_W +: XID_W];
          r_xid[2][i] <= ipsum_XID[i*XID_W +: XID_W];
          r_xid[3][i] <= opsum_XID[i*XID_W +: XID_W];
        end
        for (int r = 0; r < ROWS; r++) begin
          r_yid[0][r] <= filter_YID[r*YID_W +: YID_W];
          r_yid[1][r] <= ifmap_YID[r*YID_W +: YID_W];
          r_yid[2][r] <= ipsum_YID[r*YID_W +: YID_W];
          r_yid[3][r] <= opsum_YID[r*YID_W +: YID_W];
        end
      end else begin
        r_h <= r_h;
        r_w <= r_w;
      end
    end
  end

  assign cfg_valid = r_valid;
  assign cfg_type  = r_type;
  assign cfg_is_y  = r_is_y;
  assign cfg_row   = r_row;
  assign cfg_col   = r_col;
  assign cfg_id    = r_id;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
